// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM arbiter and other sorter-side arbiters.
package rom_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // Tag id is sized for up to four requesters.
  localparam int TAG_ID_W = 2;
  localparam int TAG_W    = TAG_ID_W + 1;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Client/ROM bus of the ROM arbiter, plus debug taps of its internal state.
interface rom_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8
);
  import rom_arb_pkg::*;

  // Handshake: client i holds req[i] (and its addr slice) until it sees gnt[i];
  // the beat is accepted at the rising edge where req[i] & gnt[i]. rvalid[i]
  // marks the single cycle in which rdata belongs to client i; there is no
  // back-pressure on read data.
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               busy;

  state_t             dbg_state;
  logic [1:0]         dbg_rr_ptr;
  logic [3:0]         dbg_bcnt;

  modport slave (
    input  req, addr, rom_data,
    output gnt, rom_addr, rvalid, rdata, busy,
    output dbg_state, dbg_rr_ptr, dbg_bcnt
  );

  modport master (
    output req, addr, rom_data,
    input  gnt, rom_addr, rvalid, rdata, busy,
    input  dbg_state, dbg_rr_ptr, dbg_bcnt
  );

endinterface

// File: rtl/rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after i_ptr,
// searching cyclically; excluded requesters are skipped.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic [N-1:0]  i_excl,
  output logic [N-1:0]  o_gnt
);

  logic [N-1:0] w_elig;

  assign w_elig = i_req & ~i_excl;

  // Scan farthest-first so the closest eligible slot is written last and wins.
  always_comb begin
    o_gnt = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (w_elig[idx]) o_gnt = N'(1) << idx;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin, burst-capable arbiter sharing one registered-output ROM between
// NREQ read clients, with a tag pipeline steering each read back to its owner.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int AW        = 4,
  parameter int DW        = 8,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  rom_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;
  localparam int BW = clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [PW-1:0]    r_own, w_own_nxt, w_own_inc, w_pick_ptr, w_pick_id;
  logic [BW-1:0]    r_bcnt, w_bcnt_nxt;
  logic [NREQ-1:0]  w_own_oh, w_excl, w_pick, w_gnt;
  logic             w_own_req, w_continue, w_rearb, w_accept, w_tags_busy;
  logic [AW-1:0]    r_rom_addr;
  logic [TAG_W-1:0] r_tag [RD_LAT];
  tag_t             w_tag_out;

  assign w_own_oh   = NREQ'(1) << r_own;
  assign w_own_inc  = (r_own == PW'(NREQ - 1)) ? '0 : r_own + 1'b1;
  assign w_own_req  = bus.req[r_own];
  assign w_continue = (r_state == ST_OWNED) && w_own_req && (r_bcnt < BURST_MAX);
  // Yield at the burst limit or release on a dropped req: search restarts after the owner.
  assign w_rearb    = (r_state == ST_OWNED) && !w_continue;
  assign w_pick_ptr = w_rearb ? w_own_inc : r_rr_ptr;
  assign w_excl     = (w_rearb && w_own_req) ? w_own_oh : '0;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .i_req  (bus.req),
    .i_ptr  (w_pick_ptr),
    .i_excl (w_excl),
    .o_gnt  (w_pick)
  );

  always_comb begin
    w_pick_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) w_pick_id = PW'(i);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_own_nxt    = r_own;
    w_rr_ptr_nxt = r_rr_ptr;
    w_bcnt_nxt   = r_bcnt;
    w_gnt        = '0;
    if (w_continue) begin
      w_gnt      = w_own_oh;
      w_bcnt_nxt = r_bcnt + 1'b1;
    end else begin
      if (w_rearb) w_rr_ptr_nxt = w_own_inc;
      if (|w_pick) begin
        w_gnt       = w_pick;
        w_state_nxt = ST_OWNED;
        w_own_nxt   = w_pick_id;
        w_bcnt_nxt  = BW'(1);
      end else if (w_rearb && w_own_req) begin
        w_gnt      = w_own_oh;
        w_bcnt_nxt = BW'(1);
      end else begin
        w_state_nxt = ST_IDLE;
        w_bcnt_nxt  = '0;
      end
    end
    if (reset) w_gnt = '0;
  end

  assign w_accept = |(w_gnt & bus.req);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_own      <= '0;
      r_rr_ptr   <= '0;
      r_bcnt     <= '0;
      r_rom_addr <= '0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_own    <= w_own_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_bcnt   <= w_bcnt_nxt;
      if (w_accept) r_rom_addr <= bus.addr[w_own_nxt*AW +: AW];
      r_tag[0] <= {w_accept, TAG_ID_W'(w_own_nxt)};
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  always_comb begin
    w_tags_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) w_tags_busy = w_tags_busy | r_tag[i][TAG_W-1];
  end

  assign w_tag_out      = tag_t'(r_tag[RD_LAT-1]);
  assign bus.gnt        = w_gnt;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.rvalid     = w_tag_out.valid ? (NREQ'(1) << w_tag_out.id) : '0;
  assign bus.rdata      = bus.rom_data;
  assign bus.busy       = (r_state == ST_OWNED) || w_tags_busy;
  assign bus.dbg_state  = r_state;
  assign bus.dbg_rr_ptr = 2'(r_rr_ptr);
  assign bus.dbg_bcnt   = 4'(r_bcnt);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: two-client and three-client instances, each
// with a behavioural registered-output ROM.
module tb_rom_arbiter;
  import rom_arb_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] rom_mem [16] = '{8'd5, 8'd4, 8'd2, 8'd1, 8'd10, 8'd0, 8'd12, 8'd3,
                               8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  logic [1:0] g_tab [12] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                             2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
  logic [7:0] d_tab [12] = '{8'd5, 8'd4, 8'd2, 8'd1, 8'd0, 8'd0,
                             8'd0, 8'd0, 8'd10, 8'd0, 8'd12, 8'd3};
  logic [3:0] bc_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
  logic [2:0] f_tab [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010,
                             3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001};

  logic [9:0] exp_q [$];

  // Clock / reset
  always #5 clk = ~clk;

  rom_arbiter_if #(.NREQ(2), .AW(4), .DW(8)) bus ();
  rom_arbiter_if #(.NREQ(3), .AW(4), .DW(8)) bus3 ();

  rom_arbiter #(.NREQ(2), .AW(4), .DW(8), .RD_LAT(2), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rom_arbiter #(.NREQ(3), .AW(4), .DW(8), .RD_LAT(2), .MAX_BURST(4)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  always @(posedge clk) begin
    bus.rom_data  <= rom_mem[bus.rom_addr];
    bus3.rom_data <= rom_mem[bus3.rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    bus.req  = '0;
    bus3.req = '0;
    cyc(2);
    reset = 1'b0;
  endtask

  // Scoreboard: every accepted beat of the two-client instance must come back in order
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset) begin
      exp_q.delete();
    end else begin
      check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      check("gnt_no_req", 32'(bus.gnt & ~bus.req), 32'd0);
      if (bus.rvalid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious", 32'(bus.rvalid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_id", 32'(bus.rvalid), 32'd1 << e[9:8]);
          check("sb_data", 32'(bus.rdata), 32'(e[7:0]));
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (bus.gnt[c] && bus.req[c]) exp_q.push_back({2'(c), rom_mem[bus.addr[c*4 +: 4]]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] a0, a1;
    int         wait_c [3];
    int         max_wait;

    bus.req   = '0;
    bus.addr  = '0;
    bus3.req  = '0;
    bus3.addr = '0;

    // Reset state and single client
    do_reset();
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("rst_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd0);
    check("rst_bcnt", 32'(bus.dbg_bcnt), 32'd0);
    bus.req       = 2'b01;
    bus.addr[3:0] = 4'd3;
    #1;
    check("single_gnt", 32'(bus.gnt), 32'h1);
    check("single_busy_pre", 32'(bus.busy), 32'd0);
    cyc();
    bus.req = 2'b00;
    #1;
    check("single_rom_addr", 32'(bus.rom_addr), 32'd3);
    check("single_busy_n1", 32'(bus.busy), 32'd1);
    check("single_gnt_off", 32'(bus.gnt), 32'd0);
    cyc();
    #1;
    check("single_rvalid", 32'(bus.rvalid), 32'h1);
    check("single_rdata", 32'(bus.rdata), 32'd1);
    check("single_busy_n2", 32'(bus.busy), 32'd1);
    cyc();
    #1;
    check("single_rvalid_off", 32'(bus.rvalid), 32'd0);
    check("single_busy_done", 32'(bus.busy), 32'd0);
    cyc(2);

    // Burst and yield between two continuous requesters
    do_reset();
    a0      = 4'd0;
    a1      = 4'd8;
    bus.req = 2'b11;
    for (int i = 0; i < 12; i++) begin
      bus.addr = {a1, a0};
      #1;
      check("burst_gnt", 32'(bus.gnt), 32'(g_tab[i]));
      if (i >= 2) begin
        check("burst_rvalid", 32'(bus.rvalid), 32'(g_tab[i-2]));
        check("burst_rdata", 32'(bus.rdata), 32'(d_tab[i-2]));
      end
      if (g_tab[i] == 2'b01) a0 = a0 + 4'd1;
      else a1 = a1 + 4'd1;
      cyc();
    end
    bus.req = 2'b00;
    cyc(4);

    // Sole requester runs through the burst limit without a bubble
    do_reset();
    bus.req       = 2'b10;
    bus.addr[7:4] = 4'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("sole_gnt", 32'(bus.gnt), 32'h2);
      check("sole_bcnt", 32'(bus.dbg_bcnt), 32'(bc_tab[i]));
      cyc();
    end
    bus.req = 2'b00;
    cyc(4);

    // Early release hands over in the same cycle
    do_reset();
    bus.req  = 2'b11;
    bus.addr = {4'd8, 4'd0};
    #1;
    check("early_gnt0", 32'(bus.gnt), 32'h1);
    cyc();
    bus.addr[3:0] = 4'd1;
    #1;
    check("early_gnt1", 32'(bus.gnt), 32'h1);
    cyc();
    bus.req[0] = 1'b0;
    #1;
    check("early_handover", 32'(bus.gnt), 32'h2);
    cyc();
    #1;
    check("early_rr_ptr", 32'(bus.dbg_rr_ptr), 32'd1);
    check("early_bcnt", 32'(bus.dbg_bcnt), 32'd1);
    check("early_gnt_hold", 32'(bus.gnt), 32'h2);
    bus.req = 2'b00;
    cyc(4);

    // Reset while a read is in flight
    do_reset();
    bus.req       = 2'b01;
    bus.addr[3:0] = 4'd6;
    #1;
    check("mid_gnt", 32'(bus.gnt), 32'h1);
    cyc();
    bus.req = 2'b00;
    reset   = 1'b1;
    #1;
    check("mid_rom_addr", 32'(bus.rom_addr), 32'd6);
    cyc();
    reset = 1'b0;
    #1;
    check("mid_gnt_after", 32'(bus.gnt), 32'd0);
    check("mid_rvalid_after", 32'(bus.rvalid), 32'd0);
    check("mid_busy_after", 32'(bus.busy), 32'd0);
    check("mid_rom_addr_after", 32'(bus.rom_addr), 32'd0);
    check("mid_state_after", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("mid_rr_ptr_after", 32'(bus.dbg_rr_ptr), 32'd0);
    check("mid_bcnt_after", 32'(bus.dbg_bcnt), 32'd0);
    cyc();
    #1;
    check("mid_rvalid_later", 32'(bus.rvalid), 32'd0);
    bus.req  = 2'b11;
    bus.addr = {4'd9, 4'd1};
    #1;
    check("mid_first_gnt", 32'(bus.gnt), 32'h1);
    cyc();
    bus.req = 2'b00;
    cyc(4);

    // Fairness with three continuous requesters
    do_reset();
    bus3.req  = 3'b111;
    bus3.addr = '0;
    max_wait  = 0;
    for (int c = 0; c < 3; c++) wait_c[c] = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("fair_gnt", 32'(bus3.gnt), 32'(f_tab[i]));
      for (int c = 0; c < 3; c++) begin
        if (bus3.gnt[c]) wait_c[c] = 0;
        else wait_c[c] = wait_c[c] + 1;
        if (wait_c[c] > max_wait) max_wait = wait_c[c];
      end
      cyc();
    end
    check("fair_max_wait", 32'(max_wait <= 8), 32'd1);
    bus3.req = '0;
    cyc(4);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
